// File: rtl/seq_control_unit.sv
// Control sequencer for the simple CPU datapath; steps T0..T3 and drives bus/register enables.
// Latency: fetch to done is 1 cycle (NOP/MV/MVI/MVNZ/illegal) or 3 cycles (ADD/SUB/AND).
// Backpressure: none; run is sampled only in T0 and IR must stay stable until done.
module seq_control_unit #(
    parameter  int REG_ADDR_W = 3,
    localparam int NUM_REGS   = 2**REG_ADDR_W,
    localparam int IR_W       = 3 + 2*REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic [IR_W-1:0]       IR,
    input  logic                  g_nz,
    output logic                  IRin,
    output logic                  DINout,
    output logic [NUM_REGS-1:0]   Rout,
    output logic [NUM_REGS-1:0]   Rin,
    output logic                  Gout,
    output logic                  Gin,
    output logic                  Ain,
    output logic [1:0]            alu_op,
    output logic                  done,
    output logic [1:0]            step,
    output logic                  illegal
);

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_MV   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVI  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    state_t state, state_nxt;

    logic [2:0]            opcode;
    logic [REG_ADDR_W-1:0] x_sel, y_sel;
    logic [NUM_REGS-1:0]   x_hot, y_hot;
    logic                  is_alu;

    assign opcode = IR[IR_W-1 -: 3];
    assign x_sel  = IR[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign y_sel  = IR[REG_ADDR_W-1:0];
    assign x_hot  = {{(NUM_REGS-1){1'b0}}, 1'b1} << x_sel;
    assign y_hot  = {{(NUM_REGS-1){1'b0}}, 1'b1} << y_sel;
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);

    always_ff @(posedge clock) begin
        if (reset) state <= T0;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            T0: state_nxt = run ? T1 : T0;
            T1: state_nxt = is_alu ? T2 : T0;
            T2: state_nxt = T3;
            T3: state_nxt = T0;
        endcase
    end

    always_comb begin
        IRin    = 1'b0;
        DINout  = 1'b0;
        Rout    = '0;
        Rin     = '0;
        Gout    = 1'b0;
        Gin     = 1'b0;
        Ain     = 1'b0;
        alu_op  = 2'b00;
        done    = 1'b0;
        step    = 2'b00;
        illegal = 1'b0;
        // Reset masks every output, including the step indicator.
        if (!reset) begin
            step = state;
            case (state)
                T0: IRin = run;
                T1: begin
                    case (opcode)
                        OP_NOP: done = 1'b1;
                        OP_MV: begin
                            Rout = y_hot;
                            Rin  = x_hot;
                            done = 1'b1;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            Rin    = x_hot;
                            done   = 1'b1;
                        end
                        OP_MVNZ: begin
                            Rout = g_nz ? y_hot : '0;
                            Rin  = g_nz ? x_hot : '0;
                            done = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            Rout = x_hot;
                            Ain  = 1'b1;
                        end
                        OP_ILL: begin
                            done    = 1'b1;
                            illegal = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    Rout = y_hot;
                    Gin  = 1'b1;
                    case (opcode)
                        OP_ADD:  alu_op = 2'b01;
                        OP_SUB:  alu_op = 2'b10;
                        OP_AND:  alu_op = 2'b11;
                        default: alu_op = 2'b00;
                    endcase
                end
                T3: begin
                    Gout = 1'b1;
                    Rin  = x_hot;
                    done = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit: stimulus pushes hand-computed outputs, a monitor pops and compares.
module tb_seq_control_unit;

    logic       clock;
    logic       reset;
    logic       run;
    logic [8:0] IR;
    logic       g_nz;
    logic       IRin, DINout, Gout, Gin, Ain, done, illegal;
    logic [7:0] Rout, Rin;
    logic [1:0] alu_op, step;

    typedef struct packed {
        logic       irin;
        logic       dinout;
        logic [7:0] rout;
        logic [7:0] rin;
        logic       gout;
        logic       gin;
        logic       ain;
        logic [1:0] alu;
        logic       done;
        logic [1:0] step;
        logic       ill;
    } outv_t;

    typedef struct {
        string name;
        outv_t v;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    seq_control_unit #(.REG_ADDR_W(3)) dut (
        .clock(clock), .reset(reset), .run(run), .IR(IR), .g_nz(g_nz),
        .IRin(IRin), .DINout(DINout), .Rout(Rout), .Rin(Rin), .Gout(Gout),
        .Gin(Gin), .Ain(Ain), .alu_op(alu_op), .done(done), .step(step),
        .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: compare the DUT output vector against the next expected entry.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            outv_t a;
            e = exp_q.pop_front();
            a = '{IRin, DINout, Rout, Rin, Gout, Gin, Ain, alu_op, done, step, illegal};
            tests++;
            if (a !== e.v) begin
                failed++;
                $display("FAIL %s: got irin=%b din=%b rout=%b rin=%b gout=%b gin=%b ain=%b alu=%b done=%b step=%b ill=%b, want irin=%b din=%b rout=%b rin=%b gout=%b gin=%b ain=%b alu=%b done=%b step=%b ill=%b",
                         e.name, a.irin, a.dinout, a.rout, a.rin, a.gout, a.gin, a.ain, a.alu, a.done, a.step, a.ill,
                         e.v.irin, e.v.dinout, e.v.rout, e.v.rin, e.v.gout, e.v.gin, e.v.ain, e.v.alu, e.v.done, e.v.step, e.v.ill);
            end
        end
    end

    // One clock of stimulus plus the outputs expected during that cycle.
    task automatic cyc(input string name, input logic rst, input logic rn, input logic [8:0] ir,
                       input logic gnz, input logic e_irin, input logic e_din,
                       input logic [7:0] e_rout, input logic [7:0] e_rin, input logic e_gout,
                       input logic e_gin, input logic e_ain, input logic [1:0] e_alu,
                       input logic e_done, input logic [1:0] e_step, input logic e_ill);
        exp_t e;
        @(posedge clock);
        #1;
        reset = rst;
        run   = rn;
        IR    = ir;
        g_nz  = gnz;
        e.name = name;
        e.v    = '{e_irin, e_din, e_rout, e_rin, e_gout, e_gin, e_ain, e_alu, e_done, e_step, e_ill};
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b1;
        IR    = 9'b0;
        g_nz  = 1'b0;

        //   name          rst run IR            gnz irin din rout         rin          gout gin ain alu    done step   ill
        cyc("reset_c1",     1, 1, 9'b001_000_001, 0, 0, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("reset_c2",     1, 1, 9'b001_000_001, 0, 0, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("mv_t0",        0, 1, 9'b001_000_001, 0, 1, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("mv_t1",        0, 0, 9'b001_000_001, 0, 0, 0, 8'b00000010, 8'b00000001, 0, 0, 0, 2'b00, 1, 2'd1, 0);
        cyc("add_t0",       0, 1, 9'b010_011_100, 0, 1, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("add_t1",       0, 0, 9'b010_011_100, 0, 0, 0, 8'b00001000, 8'b00000000, 0, 0, 1, 2'b00, 0, 2'd1, 0);
        cyc("add_t2",       0, 0, 9'b010_011_100, 0, 0, 0, 8'b00010000, 8'b00000000, 0, 1, 0, 2'b01, 0, 2'd2, 0);
        cyc("add_t3",       0, 0, 9'b010_011_100, 0, 0, 0, 8'b00000000, 8'b00001000, 1, 0, 0, 2'b00, 1, 2'd3, 0);
        cyc("sub_t0",       0, 1, 9'b011_101_110, 0, 1, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("sub_t1",       0, 0, 9'b011_101_110, 0, 0, 0, 8'b00100000, 8'b00000000, 0, 0, 1, 2'b00, 0, 2'd1, 0);
        cyc("sub_t2",       0, 0, 9'b011_101_110, 0, 0, 0, 8'b01000000, 8'b00000000, 0, 1, 0, 2'b10, 0, 2'd2, 0);
        cyc("sub_t3",       0, 0, 9'b011_101_110, 0, 0, 0, 8'b00000000, 8'b00100000, 1, 0, 0, 2'b00, 1, 2'd3, 0);
        cyc("and_t0",       0, 1, 9'b101_110_111, 0, 1, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("and_t1",       0, 1, 9'b101_110_111, 0, 0, 0, 8'b01000000, 8'b00000000, 0, 0, 1, 2'b00, 0, 2'd1, 0);
        cyc("and_t2",       0, 0, 9'b101_110_111, 0, 0, 0, 8'b10000000, 8'b00000000, 0, 1, 0, 2'b11, 0, 2'd2, 0);
        cyc("and_t3",       0, 0, 9'b101_110_111, 0, 0, 0, 8'b00000000, 8'b01000000, 1, 0, 0, 2'b00, 1, 2'd3, 0);
        cyc("mvnz0_t0",     0, 1, 9'b110_010_011, 0, 1, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("mvnz0_t1",     0, 0, 9'b110_010_011, 0, 0, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 1, 2'd1, 0);
        cyc("mvnz1_t0",     0, 1, 9'b110_010_011, 1, 1, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("mvnz1_t1",     0, 0, 9'b110_010_011, 1, 0, 0, 8'b00001000, 8'b00000100, 0, 0, 0, 2'b00, 1, 2'd1, 0);
        cyc("ill_t0",       0, 1, 9'b111_000_000, 0, 1, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("ill_t1",       0, 1, 9'b111_000_000, 0, 0, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 1, 2'd1, 1);
        cyc("ill_b2b_t0",   0, 1, 9'b111_000_000, 0, 1, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("ill_b2b_t1",   0, 1, 9'b111_000_000, 0, 0, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 1, 2'd1, 1);
        cyc("abort_t0",     0, 1, 9'b010_011_100, 0, 1, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("abort_t1",     0, 0, 9'b010_011_100, 0, 0, 0, 8'b00001000, 8'b00000000, 0, 0, 1, 2'b00, 0, 2'd1, 0);
        cyc("abort_rst_t2", 1, 0, 9'b010_011_100, 0, 0, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("idle_a",       0, 0, 9'b010_011_100, 0, 0, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("idle_b",       0, 0, 9'b010_011_100, 0, 0, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("mvi_t0",       0, 1, 9'b100_111_000, 0, 1, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("mvi_t1",       0, 0, 9'b100_111_000, 0, 0, 1, 8'b00000000, 8'b10000000, 0, 0, 0, 2'b00, 1, 2'd1, 0);
        cyc("addxx_t0",     0, 1, 9'b010_010_010, 0, 1, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("addxx_t1",     0, 0, 9'b010_010_010, 0, 0, 0, 8'b00000100, 8'b00000000, 0, 0, 1, 2'b00, 0, 2'd1, 0);
        cyc("addxx_t2",     0, 0, 9'b010_010_010, 0, 0, 0, 8'b00000100, 8'b00000000, 0, 1, 0, 2'b01, 0, 2'd2, 0);
        cyc("addxx_t3",     0, 0, 9'b010_010_010, 0, 0, 0, 8'b00000000, 8'b00000100, 1, 0, 0, 2'b00, 1, 2'd3, 0);
        cyc("nop_t0",       0, 1, 9'b000_001_010, 0, 1, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);
        cyc("nop_t1",       0, 0, 9'b000_001_010, 0, 0, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 1, 2'd1, 0);
        cyc("final_idle",   0, 0, 9'b000_001_010, 0, 0, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 2'b00, 0, 2'd0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            failed++;
            $display("FAIL drain: %0d expected cycles never checked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seq_control_unit.md
Name: seq_control_unit

Overview:
- Parametrised successor to the basic CPU control unit; owns its own instruction step counter instead of taking one externally.
- Decodes the IR in the CPU datapath and sequences the register-file, A/G register, ALU and DIN-bus enables, one step per clock.
- Extends the instruction set with AND and MVNZ (move if G not zero) and adds illegal-opcode reporting.
- Sits between the instruction register and the bus mux and register enables.

Parameters:
- REG_ADDR_W, 3: register-select field width; register count NUM_REGS = 2**REG_ADDR_W; legal values 1..4.
- IR_W, 3+2*REG_ADDR_W: instruction width, derived; must not be overridden independently.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous active-high reset.
- run  in  1  start request, sampled only in state T0.
- IR  in  IR_W  instruction {opcode[2:0], X[REG_ADDR_W-1:0], Y[REG_ADDR_W-1:0]}; X is destination, Y is source.
- g_nz  in  1  high when the G register is non-zero; used by MVNZ.
- IRin  out  1  load IR from DIN.
- DINout  out  1  drive DIN onto the bus.
- Rout  out  NUM_REGS  one-hot register-to-bus enable.
- Rin  out  NUM_REGS  one-hot register load.
- Gout  out  1  drive G onto the bus.
- Gin  out  1  load G.
- Ain  out  1  load A.
- alu_op  out  2  00 NOP, 01 ADD, 10 SUB, 11 AND.
- done  out  1  instruction complete, single-cycle pulse.
- step  out  2  current step T0..T3.
- illegal  out  1  illegal-opcode flag, pulsed with done.

Behaviour:
- State machine: T0, T1, T2, T3, stored in a 2-bit register; `step` equals the state encoding.
- All control outputs are combinational from the state, IR and g_nz. Every output is 0 except as listed per step below.
- Reset: while reset is high, all outputs are forced to 0. On the next edge the state becomes T0.
- Reset mid-instruction: aborts the instruction with no done pulse; T0 is entered on the next clock.
- T0:
  - IRin = run.
  - If run is high, next state is T1; otherwise stay in T0.
  - Run is ignored in T1–T3; deasserting it mid-instruction has no effect.
- Opcodes and steps:
  - 000 NOP: T1: done.
  - 001 MV: T1: Rout[Y], Rin[X], done.
  - 100 MVI: T1: DINout, Rin[X], done.
  - 110 MVNZ: T1: done. Rout[Y] and Rin[X] are asserted only if g_nz is high.
  - 010 ADD, 011 SUB, 101 AND, three steps:
    - T1: Rout[X], Ain.
    - T2: Rout[Y], Gin, alu_op = 01 / 10 / 11 respectively; alu_op is 00 in every other step.
    - T3: Gout, Rin[X], done.
  - 111: T1: done, illegal. No register is written.
- The cycle with done high always returns to T0 on the next edge.
- Back-to-back instructions: if run is high in the T0 following done, the next fetch begins with no bubble.
- Rout and Rin are exactly one-hot when active and all-zero otherwise.
- X == Y is legal. For MV it is a self-move; for ADD it doubles X.
- IR must be stable from T1 through the done cycle; this is the caller's guarantee, not checked by the block.
- Latency from the T0 fetch to done: 1 cycle for NOP/MV/MVI/MVNZ/illegal; 3 cycles for ADD/SUB/AND.

Test Plan (REG_ADDR_W=3):
- Reset held for 2 cycles, then run=1 in T0 -> IRin=1, step=00; the next cycle has step=01. During reset, all outputs are 0.
- MV, IR=001_000_001 -> in T1: Rout=00000010, Rin=00000001, done=1; the following cycle has step=00.
- ADD, IR=010_011_100 -> T1: Rout=00001000 with Ain. T2: Rout=00010000, Gin, alu_op=01. T3: Gout, Rin=00001000, done. The same sequence for SUB (IR=011_101_110) has alu_op=10 in T2, and for AND (IR=101_110_111) alu_op=11 in T2.
- MVNZ, IR=110_010_011:
  - With g_nz=0: done=1 and Rin=0 in T1.
  - With g_nz=1: Rout=00001000 and Rin=00000100 in T1.
- IR=111_000_000 -> T1: done=1, illegal=1, Rin=0. The same IR with run held high continuously shows a fetch, then done, then a fetch again, with no idle cycle.
- Reset asserted in T2 of an ADD -> no done pulse, all outputs 0 during reset, step=00 afterwards. With run=0 in T0, the block stays in T0 with IRin=0.
